// File: rtl/survival_score_pkg.sv
// Shared types for the survival score timer: FSM states and score digit limits.
// Optional high-score register enabled by SURVIVAL_SCORE_TIMER_HISCORE_EN in the top.
package survival_score_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} score_state_e;
  typedef logic [3:0] digit_t;
  localparam digit_t BCD_MAX = 4'd9;
  localparam digit_t HEX_MAX = 4'hF;
endpackage

// File: rtl/survival_score_timer_digit.sv
// One score digit with ripple carry; wraps at 9 (BCD) or F (hex).
// max_nxt predicts is_max after this edge so saturation can be flagged on the same edge.
module score_digit_counter
  import survival_score_pkg::*;
#(
  parameter int BCD = 1
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   clear,
  input  logic   inc_in,
  output digit_t q,
  output logic   carry_out,
  output logic   is_max,
  output logic   max_nxt
);
  localparam digit_t MAX = (BCD != 0) ? BCD_MAX : HEX_MAX;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    q <= '0;
    else if (clear)  q <= '0;
    else if (inc_in) q <= is_max ? '0 : q + 4'd1;
  end

  assign is_max    = (q == MAX);
  assign carry_out = inc_in && is_max;
  assign max_nxt   = !clear && (inc_in ? (q == MAX - 4'd1) : is_max);
endmodule

// File: rtl/survival_score_timer.sv
// Survival-time score counter: prescaled game tick, start/collide/pause FSM, saturating digits.
// Define SURVIVAL_SCORE_TIMER_HISCORE_EN to add the hi_digits best-score register.
module survival_score_timer
  import survival_score_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int NUM_DIGITS = 6,
  parameter int BCD        = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic                    collide,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    running,
  output logic                    frozen,
  output logic                    saturated
`ifdef SURVIVAL_SCORE_TIMER_HISCORE_EN
  ,
  output logic [4*NUM_DIGITS-1:0] hi_digits
`endif
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("survival_score_timer: CLK_HZ/TICK_HZ must be >= 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("survival_score_timer: NUM_DIGITS must be 1..8");
  end

  score_state_e state, state_nxt;
  logic [PW-1:0]         presc;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS-1:0] dig_max, dig_max_nxt;
  logic at_tc, inc, all_max, carry_unused;

  assign at_tc   = (state == S_RUN) && !pause && (presc == TC);
  assign all_max = &dig_max;
  // collide and start both pre-empt the increment on a terminal-count edge
  assign inc      = at_tc && !collide && !start && !all_max;
  assign carry[0] = inc;
  assign carry_unused = carry[NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    score_digit_counter #(.BCD(BCD)) u_digit (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .clear     (start),
      .inc_in    (carry[g]),
      .q         (digits[4*g +: 4]),
      .carry_out (carry[g+1]),
      .is_max    (dig_max[g]),
      .max_nxt   (dig_max_nxt[g])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (start) state_nxt = S_RUN;
                else if (collide) state_nxt = S_FROZEN;
      S_FROZEN: if (start) state_nxt = S_RUN;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      presc     <= '0;
      tick      <= 1'b0;
      running   <= 1'b0;
      frozen    <= 1'b0;
      saturated <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick      <= inc;
      running   <= (state_nxt == S_RUN);
      frozen    <= (state_nxt == S_FROZEN);
      saturated <= &dig_max_nxt;
      if (start)
        presc <= '0;
      else if ((state == S_RUN) && !pause && !collide)
        presc <= (presc == TC) ? '0 : presc + 1'b1;
    end
  end

`ifdef SURVIVAL_SCORE_TIMER_HISCORE_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      hi_digits <= '0;
    else if ((state == S_RUN) && !start && collide && (digits > hi_digits))
      hi_digits <= digits;
  end
`endif
endmodule

// File: tb/tb_survival_score_timer.sv
// Bench for survival_score_timer: three instances (BCD x6, BCD x2, hex x6) driven in lockstep against an integer score model.
module tb_survival_score_timer;
  localparam int DIV = 10;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic start = 1'b0, collide = 1'b0, pause = 1'b0;
  logic [23:0] d0, d2;
  logic [7:0]  d1;
  logic [2:0]  tk, rn, fz, st;
  logic [23:0] h0, h2;
  logic [7:0]  h1;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

`ifdef SURVIVAL_SCORE_TIMER_HISCORE_EN
  survival_score_timer #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(6), .BCD(1)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .collide(collide), .pause(pause),
    .digits(d0), .tick(tk[0]), .running(rn[0]), .frozen(fz[0]), .saturated(st[0]), .hi_digits(h0));
  survival_score_timer #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2), .BCD(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .collide(collide), .pause(pause),
    .digits(d1), .tick(tk[1]), .running(rn[1]), .frozen(fz[1]), .saturated(st[1]), .hi_digits(h1));
  survival_score_timer #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(6), .BCD(0)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .collide(collide), .pause(pause),
    .digits(d2), .tick(tk[2]), .running(rn[2]), .frozen(fz[2]), .saturated(st[2]), .hi_digits(h2));
`else
  survival_score_timer #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(6), .BCD(1)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .collide(collide), .pause(pause),
    .digits(d0), .tick(tk[0]), .running(rn[0]), .frozen(fz[0]), .saturated(st[0]));
  survival_score_timer #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2), .BCD(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .collide(collide), .pause(pause),
    .digits(d1), .tick(tk[1]), .running(rn[1]), .frozen(fz[1]), .saturated(st[1]));
  survival_score_timer #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(6), .BCD(0)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .collide(collide), .pause(pause),
    .digits(d2), .tick(tk[2]), .running(rn[2]), .frozen(fz[2]), .saturated(st[2]));
  assign h0 = '0;
  assign h1 = '0;
  assign h2 = '0;
`endif

  // Reference model: score is a plain integer, converted to digits only for comparison.
  int     base[3] = '{10, 10, 16};
  int     nd[3]   = '{6, 2, 6};
  int     m_st[3];        // 0 idle, 1 run, 2 frozen
  int     m_ph[3];        // clocks elapsed in the current tick period
  longint m_score[3];
  longint m_hi[3];
  bit     m_tick[3];

  function automatic longint maxv(int i);
    longint p = 1;
    for (int k = 0; k < nd[i]; k++) p = p * base[i];
    return p - 1;
  endfunction

  function automatic logic [31:0] todig(longint s, int b, int n);
    logic [31:0] r = '0;
    longint v = s;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(v % b);
      v = v / b;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_ph[i] = 0; m_score[i] = 0; m_hi[i] = 0; m_tick[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      m_tick[i] = 0;
      if (start) begin
        m_st[i] = 1; m_score[i] = 0; m_ph[i] = 0;
      end else if (m_st[i] == 1) begin
        if (collide) begin
          m_st[i] = 2;
          if (m_score[i] > m_hi[i]) m_hi[i] = m_score[i];
        end else if (!pause) begin
          if (m_ph[i] == DIV - 1) begin
            m_ph[i] = 0;
            if (m_score[i] < maxv(i)) begin
              m_score[i]++;
              m_tick[i] = 1;
            end
          end else begin
            m_ph[i]++;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [67:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: got = {32'(h0), 32'(d0), tk[0], rn[0], fz[0], st[0]};
        1: got = {32'(h1), 32'(d1), tk[1], rn[1], fz[1], st[1]};
        default: got = {32'(h2), 32'(d2), tk[2], rn[2], fz[2], st[2]};
      endcase
`ifdef SURVIVAL_SCORE_TIMER_HISCORE_EN
      exp[67:36] = todig(m_hi[i], base[i], nd[i]);
`else
      exp[67:36] = '0;
`endif
      exp[35:4] = todig(m_score[i], base[i], nd[i]);
      exp[3:0]  = {m_tick[i], m_st[i] == 1, m_st[i] == 2, m_score[i] == maxv(i)};
      total++;
      assert (got === exp) else begin
        bad++;
        $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, got, exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic c, input logic p);
    @(negedge Clk);
    start = s; collide = c; pause = p;
    @(posedge Clk);
    model_edge();
    #1;
    check_all("cycle");
  endtask

  initial begin
    int ticks_at[$];
    int found, nt;
    logic p;

    model_reset();
    #2;
    check_all("reset");
    chk("reset_digits", 32'(d0), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // 1: first ticks at cycles 10 and 20
    cyc(1, 0, 0);
    for (int k = 1; k <= 25; k++) begin
      cyc(0, 0, 0);
      if (tk[0]) ticks_at.push_back(k);
    end
    chk("t1_tick_count", 32'(ticks_at.size()), 32'd2);
    if (ticks_at.size() == 2) begin
      chk("t1_tick0", 32'(ticks_at[0]), 32'd10);
      chk("t1_tick1", 32'(ticks_at[1]), 32'd20);
    end
    chk("t1_digits", 32'(d0), 32'h000002);
    chk("t1_running", 32'(rn[0]), 32'd1);

    // 2: decimal vs hex carry
    cyc(1, 0, 0);
    repeat (100) cyc(0, 0, 0);
    chk("t2_bcd10", 32'(d0), 32'h000010);
    chk("t2_hex10", 32'(d2), 32'h00000A);
    repeat (60) cyc(0, 0, 0);
    chk("t2_hex16", 32'(d2), 32'h000010);
    chk("t2_bcd16", 32'(d0), 32'h000016);

    // 3: collide on terminal count at score 3
    cyc(1, 0, 0);
    repeat (39) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("t3_digits", 32'(d0), 32'h3);
    chk("t3_frozen", 32'(fz[0]), 32'd1);
    chk("t3_tick", 32'(tk[0]), 32'd0);
    repeat (12) cyc(0, 1, 0);
    chk("t3_hold", 32'(d0), 32'h3);
    cyc(1, 0, 0);
    chk("t3_restart_digits", 32'(d0), 32'h0);
    chk("t3_restart_running", 32'(rn[0]), 32'd1);

    // 4: pause at prescaler 4, next tick 6 cycles after release
    repeat (4) cyc(0, 0, 0);
    repeat (15) cyc(0, 0, 1);
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 0);
      if (tk[0] && found == 0) found = k;
    end
    chk("t4_gap", 32'(found), 32'd6);

    // high score: rounds of 5 then 3
    cyc(1, 0, 0);
    repeat (50) cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (30) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("hs_round2_digits", 32'(d0), 32'h3);
`ifdef SURVIVAL_SCORE_TIMER_HISCORE_EN
    chk("hs_best", 32'(h0), 32'h5);
`endif

    // 5: two-digit saturation
    cyc(1, 0, 0);
    repeat (99 * DIV) cyc(0, 0, 0);
    chk("t5_sat", 32'(st[1]), 32'd1);
    chk("t5_digits", 32'(d1), 32'h99);
    nt = 0;
    for (int k = 0; k < 5 * DIV; k++) begin
      cyc(0, 0, 0);
      if (tk[1]) nt++;
    end
    chk("t5_no_tick", 32'(nt), 32'd0);
    chk("t5_hold", 32'(d1), 32'h99);

    // random start/collide/pause traffic
    p = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) p = ~p;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0), p);
    end

    // 6: asynchronous reset between edges
    cyc(1, 0, 0);
    repeat (37) cyc(0, 0, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("t6_running", 32'(rn[0]), 32'd0);
    chk("t6_digits", 32'(d0), 32'h0);
`ifdef SURVIVAL_SCORE_TIMER_HISCORE_EN
    chk("t6_hi", 32'(h0), 32'h0);
`endif
    @(negedge Clk);
    Reset_n = 1'b1;
    // idle ignores collide and pause
    repeat (12) cyc(0, 1, 1);
    chk("idle_running", 32'(rn[0] | fz[0]), 32'd0);
    cyc(1, 0, 0);
    repeat (12) cyc(0, 0, 0);
    chk("post_reset_digits", 32'(d0), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
